load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 107 ++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the pipeline request/response handshake and the data-memory bus of the load/store unit.
// slave is the LSU side, master is the pipeline-plus-memory side.
interface load_store_unit_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic        REQ_BYTE;
  logic        REQ_SIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic [31:0] A;
  logic [31:0] WD;
  logic        MemWrite;
  logic        ByteORword;
  logic        ByteORwordS;
  logic [31:0] RD;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_BYTE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, RSP_READY, RD,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, A, WD, MemWrite, ByteORword, ByteORwordS
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_BYTE, REQ_SIGNED, REQ_ADDR, REQ_WDATA, RSP_READY, RD,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, A, WD, MemWrite, ByteORword, ByteORwordS
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between pipeline and data memory, RD_LAT-cycle reads.
// Optional misaligned-word trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  load_store_unit_if.slave  bus
);

  // state  | meaning
  // IDLE   | ready for a request (when EN=1)
  // ACCESS | address/data on the memory bus, write strobe for stores
  // WAIT   | load read latency, counted down in cnt_q
  // RESP   | response held until RSP_READY
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        we_q;
  logic        byte_q;
  logic        signed_q;
  logic        err_q;
  logic [2:0]  cnt_q;
  logic        misalign;
  logic        bus_active;
  logic        in_resp;

  assign misalign = TRAP_EN & ~bus.REQ_BYTE & (bus.REQ_ADDR[1:0] != 2'b00);

  always_comb begin
    rdata_d = bus.RD;
    if (byte_q) begin
      rdata_d = {{24{signed_q & bus.RD[7]}}, bus.RD[7:0]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (EN) begin
      case (state_q)
        IDLE: begin
          if (bus.REQ_VALID) begin
            addr_q   <= bus.REQ_ADDR;
            wdata_q  <= bus.REQ_WDATA;
            we_q     <= bus.REQ_WE;
            byte_q   <= bus.REQ_BYTE;
            signed_q <= bus.REQ_SIGNED;
            err_q    <= misalign;
            rdata_q  <= '0;
            cnt_q    <= LAT_M1;
            state_q  <= misalign ? RESP : ACCESS;
          end
        end
        ACCESS: state_q <= we_q ? RESP : WAIT;
        WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q <= rdata_d;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (bus.RSP_READY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_active = (state_q == ACCESS) || (state_q == WAIT);
  assign in_resp    = (state_q == RESP);

  // RST_N gates ready so it reads 0 while reset is held even with EN high
  assign bus.REQ_READY   = RST_N & EN & (state_q == IDLE);
  assign bus.A           = bus_active ? {addr_q[31:2], byte_q ? addr_q[1:0] : 2'b00} : '0;
  assign bus.WD          = bus_active ? wdata_q : '0;
  assign bus.MemWrite    = EN & (state_q == ACCESS) & we_q;
  assign bus.ByteORword  = bus_active & byte_q & ~we_q;
  assign bus.ByteORwordS = bus_active & byte_q & we_q;
  assign bus.RSP_VALID   = in_resp;
  assign bus.RSP_DATA    = in_resp ? rdata_q : '0;
  assign bus.RSP_ERR     = TRAP_EN & in_resp & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, random traffic vs a byte-array model,
// and hand sequences for backpressure, enable freeze, mid-transaction reset and RD_LAT=3.
module tb_load_store_unit;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic EN = 1'b1;
  logic mem_clr = 1'b1;

  int checks = 0;
  int failures = 0;

  load_store_unit_if bus();
  load_store_unit_if bus3();

  load_store_unit #(.RD_LAT(1)) dut  (.CLK(CLK), .RST_N(RST_N), .EN(EN), .bus(bus));
  load_store_unit #(.RD_LAT(3)) dut3 (.CLK(CLK), .RST_N(RST_N), .EN(EN), .bus(bus3));

  always #5 CLK = ~CLK;

  // Word-organised memory device attached to the main DUT
  logic [31:0] dev_mem [0:63];
  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= '0;
    end else if (bus.MemWrite) begin
      if (bus.ByteORwordS) dev_mem[bus.A[7:2]][{bus.A[1:0], 3'b000} +: 8] <= bus.WD[7:0];
      else                 dev_mem[bus.A[7:2]] <= bus.WD;
    end
  end

  always_comb begin
    bus.RD = dev_mem[bus.A[7:2]];
    if (bus.ByteORword) bus.RD = {24'h5A5A5A, dev_mem[bus.A[7:2]][{bus.A[1:0], 3'b000} +: 8]};
  end

  // Reference model: flat little-endian byte memory
  logic [7:0] ref_mem [0:255];

  typedef struct {
    logic        we;
    logic        byt;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_mw;
    logic [31:0] exp_a;
    logic        exp_bw;
    logic        exp_bws;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_flags"}, 32'({bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.MemWrite,
                             bus.ByteORword, bus.ByteORwordS}), 32'h0);
    chk({nm, "_buses"}, bus.A | bus.WD | bus.RSP_DATA, 32'h0);
  endtask

  task automatic ref_store(input logic byt, input logic [31:0] addr, input logic [31:0] wdata);
    if (byt) ref_mem[addr[7:0]] = wdata[7:0];
    else for (int i = 0; i < 4; i++) ref_mem[32'({addr[7:2], 2'b00}) + i] = wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic byt, input logic sgn, input logic [31:0] addr);
    logic [7:0] b;
    int base;
    if (byt) begin
      b = ref_mem[addr[7:0]];
      return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    end
    base = 32'({addr[7:2], 2'b00});
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic vec_t model_vec(input logic we, input logic byt, input logic sgn,
                                     input logic [31:0] addr, input logic [31:0] wdata);
    vec_t v;
    logic trap;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = !byt && (addr[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    v.we = we; v.byt = byt; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_data = (we || trap) ? 32'h0 : ref_load(byt, sgn, addr);
    v.exp_err  = trap;
    v.exp_lat  = trap ? 1 : (we ? 2 : 3);
    v.exp_mw   = (we && !trap) ? 1 : 0;
    v.exp_a    = byt ? addr : {addr[31:2], 2'b00};
    v.exp_bw   = byt && !we;
    v.exp_bws  = byt && we;
    return v;
  endfunction

  // One request/response with RSP_READY high; lat counts edges from accept (accept = 1)
  task automatic run_txn(input logic we, input logic byt, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic err, output int lat,
                         output int mw, output logic [31:0] a_s, output logic [31:0] wd_s,
                         output logic bw_s, output logic bws_s, output logic rdy_s,
                         output logic tmo);
    int guard;
    logic first;
    @(negedge CLK);
    bus.REQ_WE = we; bus.REQ_BYTE = byt; bus.REQ_SIGNED = sgn;
    bus.REQ_ADDR = addr; bus.REQ_WDATA = wdata;
    bus.REQ_VALID = 1'b1; bus.RSP_READY = 1'b1;
    guard = 0;
    while (!bus.REQ_READY && guard < 50) begin @(negedge CLK); guard++; end
    tmo = (guard >= 50);
    @(posedge CLK); #1 bus.REQ_VALID = 1'b0;
    lat = 1; mw = 0; a_s = '0; wd_s = '0; bw_s = 1'b0; bws_s = 1'b0; first = 1'b1;
    @(negedge CLK);
    while (!bus.RSP_VALID && lat < 50) begin
      if (first) begin
        a_s = bus.A; wd_s = bus.WD; bw_s = bus.ByteORword; bws_s = bus.ByteORwordS;
        first = 1'b0;
      end
      if (bus.MemWrite) mw++;
      @(posedge CLK); lat++; @(negedge CLK);
    end
    if (lat >= 50) tmo = 1'b1;
    data = bus.RSP_DATA; err = bus.RSP_ERR; rdy_s = bus.REQ_READY;
    @(posedge CLK);
  endtask

  task automatic check_txn(input vec_t v);
    logic [31:0] data, a_s, wd_s;
    logic err, bw_s, bws_s, rdy_s, tmo;
    int lat, mw;
    run_txn(v.we, v.byt, v.sgn, v.addr, v.wdata, data, err, lat, mw, a_s, wd_s, bw_s, bws_s,
            rdy_s, tmo);
    chk("txn_timeout", 32'(tmo), 32'h0);
    chk("rsp_data", data, v.exp_data);
    chk("rsp_err", 32'(err), 32'(v.exp_err));
    chk("rsp_latency", 32'(lat), 32'(v.exp_lat));
    chk("memwrite_pulses", 32'(mw), 32'(v.exp_mw));
    chk("req_ready_in_resp", 32'(rdy_s), 32'h0);
    if (!v.exp_err) begin
      chk("mem_addr", a_s, v.exp_a);
      chk("byte_read_sel", 32'(bw_s), 32'(v.exp_bw));
      chk("byte_store_sel", 32'(bws_s), 32'(v.exp_bws));
      if (v.we) chk("mem_wdata", v.byt ? {24'h0, wd_s[7:0]} : wd_s,
                    v.byt ? {24'h0, v.wdata[7:0]} : v.wdata);
      if (v.we) ref_store(v.byt, v.addr, v.wdata);
    end
  endtask

  vec_t vecs [7];

  initial begin
    int guard, mwc;
    logic [31:0] d_exp;

    bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_BYTE = 1'b0; bus.REQ_SIGNED = 1'b0;
    bus.REQ_ADDR = '0; bus.REQ_WDATA = '0; bus.RSP_READY = 1'b0;
    bus3.REQ_VALID = 1'b0; bus3.REQ_WE = 1'b0; bus3.REQ_BYTE = 1'b0; bus3.REQ_SIGNED = 1'b0;
    bus3.REQ_ADDR = '0; bus3.REQ_WDATA = '0; bus3.RSP_READY = 1'b0; bus3.RD = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;

    //           we  byt sgn addr        wdata         exp_data      err lat mw exp_a     bw   bws
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b0, 2, 1, 32'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0, 3, 0, 32'h10, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h05, 32'hDEADBE80, 32'h0,        1'b0, 2, 1, 32'h05, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h05, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 32'h05, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h05, 32'h0,        32'h00000080, 1'b0, 3, 0, 32'h05, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h04, 32'h0,        32'h00008000, 1'b0, 3, 0, 32'h04, 1'b0, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 32'h10, 1'b0, 1'b0};
`else
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h13, 32'h0,        32'h12345678, 1'b0, 3, 0, 32'h10, 1'b0, 1'b0};
`endif

    // Reset held with EN high: everything 0, including REQ_READY
    #12;
    chk_zero("reset");
    @(negedge CLK); mem_clr = 1'b0; RST_N = 1'b1;
    #1 chk("ready_after_reset", 32'(bus.REQ_READY), 32'h1);

    foreach (vecs[i]) check_txn(vecs[i]);

    for (int n = 0; n < 40; n++) begin
      logic we, byt, sgn;
      we = 1'($urandom_range(0, 1)); byt = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      check_txn(model_vec(we, byt, sgn, 32'($urandom_range(0, 255)), $urandom));
    end

    // Response backpressure: held 5 cycles, ready only after the handshake edge
    @(negedge CLK);
    bus.REQ_WE = 1'b0; bus.REQ_BYTE = 1'b0; bus.REQ_ADDR = 32'h10;
    bus.REQ_VALID = 1'b1; bus.RSP_READY = 1'b0;
    d_exp = ref_load(1'b0, 1'b0, 32'h10);
    @(posedge CLK); #1 bus.REQ_VALID = 1'b0;
    guard = 0;
    @(negedge CLK);
    while (!bus.RSP_VALID && guard < 20) begin @(negedge CLK); guard++; end
    chk("bp_timeout", 32'(guard >= 20), 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CLK);
      chk("bp_valid_held", 32'(bus.RSP_VALID), 32'h1);
      chk("bp_data_held", bus.RSP_DATA, d_exp);
      chk("bp_req_ready_low", 32'(bus.REQ_READY), 32'h0);
    end
    bus.RSP_READY = 1'b1;
    @(posedge CLK); #1;
    chk("bp_ready_after_hs", 32'(bus.REQ_READY), 32'h1);
    chk("bp_valid_dropped", 32'(bus.RSP_VALID), 32'h0);

    // Store frozen by EN=0 for 3 edges in ACCESS: still exactly one write pulse
    @(negedge CLK);
    bus.REQ_WE = 1'b1; bus.REQ_BYTE = 1'b0; bus.REQ_ADDR = 32'h20; bus.REQ_WDATA = 32'hCAFEF00D;
    bus.REQ_VALID = 1'b1;
    @(posedge CLK); #1 bus.REQ_VALID = 1'b0; EN = 1'b0;
    mwc = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.MemWrite) mwc++;
      chk("freeze_addr", bus.A, 32'h20);
      chk("freeze_no_rsp", 32'(bus.RSP_VALID), 32'h0);
      @(posedge CLK);
    end
    @(negedge CLK);
    EN = 1'b1;
    guard = 0;
    #1;
    while (!bus.RSP_VALID && guard < 20) begin
      if (bus.MemWrite) mwc++;
      @(negedge CLK); guard++;
    end
    chk("freeze_store_pulses", 32'(mwc), 32'h1);
    ref_store(1'b0, 32'h20, 32'hCAFEF00D);
    @(posedge CLK);

    // Reset during WAIT of a load: outputs drop at once, no response afterwards
    @(negedge CLK);
    bus.REQ_WE = 1'b0; bus.REQ_ADDR = 32'h20; bus.REQ_VALID = 1'b1;
    @(posedge CLK); #1 bus.REQ_VALID = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("wait_addr_before_rst", bus.A, 32'h20);
    RST_N = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge CLK); RST_N = 1'b1;
    #1 chk("ready_after_rst_pulse", 32'(bus.REQ_READY), 32'h1);
    mwc = 0;
    repeat (4) begin @(negedge CLK); if (bus.RSP_VALID) mwc++; end
    chk("no_rsp_after_reset", 32'(mwc), 32'h0);
    check_txn(model_vec(1'b0, 1'b0, 1'b0, 32'h20, 32'h0));

    // RD_LAT=3 instance: valid 5 edges after accept, RD taken at the third WAIT edge
    @(negedge CLK);
    bus3.REQ_ADDR = 32'h40; bus3.REQ_VALID = 1'b1; bus3.RSP_READY = 1'b0;
    chk("lat3_ready", 32'(bus3.REQ_READY), 32'h1);
    @(posedge CLK); #1 bus3.REQ_VALID = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge CLK);
      bus3.RD = 32'hC0DE0000 + 32'(k);
      @(posedge CLK); #1;
      chk($sformatf("lat3_valid_edge%0d", k), 32'(bus3.RSP_VALID), 32'(k >= 5));
    end
    chk("lat3_data", bus3.RSP_DATA, 32'hC0DE0005);
    @(negedge CLK); bus3.RSP_READY = 1'b1;
    @(posedge CLK); #1;
    chk("lat3_idle", 32'(bus3.REQ_READY), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
